// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic matrix-multiply datapath.
package systolic_pkg;

  localparam int SYS_DIM          = 8;
  localparam int SYS_FLUSH_CYCLES = 3 * SYS_DIM - 2;
  localparam int SYS_CNT_W        = $clog2(SYS_FLUSH_CYCLES + 1);
  localparam int SYS_ROW_W        = $clog2(SYS_DIM);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    READ,
    DONE
  } seq_state_t;

endpackage

// File: rtl/systolic_seq_ctrl_phase_counter.sv
// Phase counter: synchronous clear (dominant), increment, and terminal-count compare.
module phase_counter
  import systolic_pkg::*;
#(
  parameter int CNT_W = SYS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_term
);

  logic [CNT_W-1:0] r_cnt;

  // Count register; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one matrix-multiply pass: clear, feed, flush, then row readout.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM          = SYS_DIM,
  parameter int FLUSH_CYCLES = 3 * DIM - 2,
  parameter int CNT_W        = $clog2(FLUSH_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   src_rd_en,
  output logic [$clog2(DIM)-1:0] src_addr,
  output logic                   mem_en,
  output logic                   zero_fill,
  output logic                   array_en,
  output logic                   array_clr,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_valid,
  input  logic                   c_ready
);

  localparam int ROW_W = $clog2(DIM);

  seq_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_src_rd_en;
  logic             r_array_clr;
  logic             r_c_valid;
  logic             r_mem_en;
  logic             r_zero_fill;

  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_term;
  logic [CNT_W-1:0] w_cnt;
  logic             w_at_term;

  // Counter control: each phase sets its own terminal count; every state exit clears it.
  always_comb begin
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_term    = '0;
    case (r_state)
      CLEAR: w_cnt_clr = 1'b1;
      FEED: begin
        w_term    = CNT_W'(DIM - 1);
        w_cnt_inc = 1'b1;
        w_cnt_clr = w_at_term;
      end
      FLUSH: begin
        w_term    = CNT_W'(FLUSH_CYCLES - 1);
        w_cnt_inc = 1'b1;
        w_cnt_clr = w_at_term;
      end
      READ: begin
        w_term    = CNT_W'(DIM - 1);
        w_cnt_inc = c_ready;
        w_cnt_clr = w_at_term && c_ready;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .i_term   (w_term),
    .o_cnt    (w_cnt),
    .o_at_term(w_at_term)
  );

  // FSM with registered outputs; datapath enables lag the state by one cycle to match source read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_src_rd_en <= 1'b0;
      r_array_clr <= 1'b0;
      r_c_valid   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_zero_fill <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_array_clr <= 1'b0;
      r_mem_en    <= (r_state == FEED) || (r_state == FLUSH);
      r_zero_fill <= (r_state == FLUSH);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= CLEAR;
            r_busy      <= 1'b1;
            r_array_clr <= 1'b1;
          end
        end
        CLEAR: begin
          r_state     <= FEED;
          r_src_rd_en <= 1'b1;
        end
        FEED: begin
          if (w_at_term) begin
            r_state     <= FLUSH;
            r_src_rd_en <= 1'b0;
          end
        end
        FLUSH: begin
          if (w_at_term) begin
            r_state   <= READ;
            r_c_valid <= 1'b1;
          end
        end
        READ: begin
          if (c_ready && w_at_term) begin
            r_state   <= DONE;
            r_c_valid <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_src_rd_en <= 1'b0;
          r_c_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign src_rd_en = r_src_rd_en;
  assign src_addr  = r_src_rd_en ? w_cnt[ROW_W-1:0] : '0;
  assign mem_en    = r_mem_en;
  assign array_en  = r_mem_en;
  assign zero_fill = r_zero_fill;
  assign array_clr = r_array_clr;
  assign c_valid   = r_c_valid;
  assign c_row     = r_c_valid ? w_cnt[ROW_W-1:0] : '0;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl at DIM=8 (FLUSH_CYCLES=22).
module tb_systolic_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       src_rd_en;
  logic [2:0] src_addr;
  logic       mem_en;
  logic       zero_fill;
  logic       array_en;
  logic       array_clr;
  logic [2:0] c_row;
  logic       c_valid;
  logic       c_ready;

  int n_pass  = 0;
  int n_total = 0;

  systolic_seq_ctrl #(.DIM(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .src_rd_en(src_rd_en),
    .src_addr (src_addr),
    .mem_en   (mem_en),
    .zero_fill(zero_fill),
    .array_en (array_en),
    .array_clr(array_clr),
    .c_row    (c_row),
    .c_valid  (c_valid),
    .c_ready  (c_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy,done,src_rd_en,src_addr,mem_en,zero_fill,array_en,array_clr,c_row,c_valid}
  logic [13:0] obs;
  assign obs = {busy, done, src_rd_en, src_addr, mem_en, zero_fill, array_en, array_clr, c_row, c_valid};

  // Hand-derived timeline of a pass with start at cycle 0 and c_ready held high.
  function automatic logic [13:0] exp_nom(input int c);
    logic       b, d, rd, men, zf, clr, cv;
    logic [2:0] addr, row;
    b    = (c >= 1) && (c <= 40);
    d    = (c == 40);
    rd   = (c >= 2) && (c <= 9);
    addr = rd ? 3'(c - 2) : 3'd0;
    men  = (c >= 3) && (c <= 32);
    zf   = (c >= 11) && (c <= 32);
    clr  = (c == 1);
    cv   = (c >= 32) && (c <= 39);
    row  = cv ? 3'(c - 32) : 3'd0;
    return {b, d, rd, addr, men, zf, men, clr, row, cv};
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b1;
    c_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 14'h0) $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, 14'h0);
      else n_pass++;
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 14'h0 || busy !== 1'b0) $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs, 14'h0);
      else n_pass++;
    end
  endtask

  // Called at a negedge in IDLE; runs cycles 0..41 of a full pass with c_ready=1.
  task automatic run_nominal(input string tag);
    c_ready = 1'b1;
    start   = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start = 1'b0;
      n_total++;
      if (obs !== exp_nom(c)) $display("FAIL %s cyc%0d: got %h want %h", tag, c, obs, exp_nom(c));
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    run_nominal("nominal");
  endtask

  task automatic test_backpressure();
    c_ready = 1'b0;
    start   = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (c_valid !== 1'b1 || c_row !== 3'(r) || done !== 1'b0)
          $display("FAIL bp_row%0d_%0d: got valid=%b row=%0d done=%b want valid=1 row=%0d done=0",
                   r, k, c_valid, c_row, done, r);
        else n_pass++;
        c_ready = (k == 2);
        @(negedge clk);
      end
    end
    c_ready = 1'b0;
    n_total++;
    if (done !== 1'b1 || c_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_done: got done=%b valid=%b busy=%b want 1 0 1", done, c_valid, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL bp_idle: got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int clr_cnt;
    clr_cnt = 0;
    c_ready = 1'b1;
    start   = 1'b1;
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) @(negedge clk);
      if (array_clr === 1'b1) clr_cnt++;
      n_total++;
      if (obs !== exp_nom(c)) $display("FAIL ign_start cyc%0d: got %h want %h", c, obs, exp_nom(c));
      else n_pass++;
    end
    n_total++;
    if (clr_cnt !== 1) $display("FAIL ign_clr_count: got %0d want 1", clr_cnt);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (array_clr !== 1'b1 || busy !== 1'b1)
      $display("FAIL ign_restart: got clr=%b busy=%b want 1 1", array_clr, busy);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 14'h0) $display("FAIL ign_abort: got %h want %h", obs, 14'h0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    c_ready = 1'b1;
    start   = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    n_total++;
    if (zero_fill !== 1'b1 || src_rd_en !== 1'b0 || mem_en !== 1'b1)
      $display("FAIL mid_flush_state: got zf=%b rd=%b men=%b want 1 0 1", zero_fill, src_rd_en, mem_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 14'h0) $display("FAIL mid_flush_async: got %h want %h", obs, 14'h0);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 14'h0) $display("FAIL mid_flush_hold%0d: got %h want %h", i, obs, 14'h0);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 14'h0) $display("FAIL mid_flush_quiet%0d: got %h want %h", i, obs, 14'h0);
      else n_pass++;
    end
    run_nominal("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    c_ready = 1'b0;
    test_reset();
    test_nominal();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_ignored_start();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
